// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA text console controller.
// Contents:
//   CON_COLS / CON_ROWS / CON_BLANK : default screen geometry and fill character
//   CODE_*                          : control bytes interpreted by the console
//   state_t                         : controller FSM state encoding
//   is_printable()                  : true for the printable ASCII range 0x20..0x7E
package vga_console_pkg;

  localparam int         CON_COLS  = 70;
  localparam int         CON_ROWS  = 30;
  localparam logic [7:0] CON_BLANK = 8'h20;

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_BLANK,
    CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/vga_console_ctrl.sv
// VGA text console controller.
// Accepts ASCII command bytes and maintains a COLS x ROWS character RAM
// (cell address = row*COLS + col) plus a text cursor. Printable bytes are
// written at the cursor, control codes move the cursor, a newline or wrap on
// the last row scrolls the whole screen up by one row, and form feed clears it.
// Ports:
//   vga_clk, rst                 : clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready/cmd_data : command byte handshake
//   ram_wren/ram_waddr/ram_wdata : registered character RAM write port
//   ram_raddr/ram_rdata          : character RAM read port (1-cycle read latency)
//   cursor_col/cursor_row        : current cursor position
//   busy                         : high while a scroll or clear is running
module vga_console_ctrl
  import vga_console_pkg::*;
#(
  parameter int         COLS  = CON_COLS,
  parameter int         ROWS  = CON_ROWS,
  parameter logic [7:0] BLANK = CON_BLANK
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic        ram_wren,
  output logic [11:0] ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic [11:0] ram_raddr,
  input  logic [7:0]  ram_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [11:0] COLS_A     = 12'(COLS);
  localparam logic [11:0] SHIFT_LAST = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] TOTAL      = 12'(COLS * ROWS);

  state_t      state;
  logic        started;
  logic        scroll_pending;
  logic [11:0] seq;
  logic [11:0] cur_addr;

  // The state register already sits in IDLE during reset, so a separate flag
  // keeps cmd_ready low until the first clock edge after reset is released.
  assign cmd_ready = started && (state == IDLE);
  assign busy      = (state == SCROLL_RD) || (state == SCROLL_WR) ||
                     (state == SCROLL_BLANK) || (state == CLEAR);
  assign cur_addr  = 12'(int'(cursor_row) * COLS + int'(cursor_col));

  // Single FSM. Write strobes are registered, so a write decided on an edge
  // is visible on the RAM port during the following cycle. In a scroll the
  // read address is set on the edge entering SCROLL_RD, the RAM returns the
  // data during SCROLL_WR, and the edge leaving SCROLL_WR registers the copy
  // write; the last copy strobe therefore shows during the first
  // SCROLL_BLANK cycle and the last blank strobe during the final one.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      started        <= 1'b0;
      scroll_pending <= 1'b0;
      seq            <= '0;
      cursor_col     <= '0;
      cursor_row     <= '0;
      ram_wren       <= 1'b0;
      ram_waddr      <= '0;
      ram_wdata      <= '0;
      ram_raddr      <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          ram_wren <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (is_printable(cmd_data)) begin
              ram_wren  <= 1'b1;
              ram_waddr <= cur_addr;
              ram_wdata <= cmd_data;
              state     <= PUT;
              if (cursor_col == LAST_COL) begin
                cursor_col <= '0;
                // On the bottom row the character is written first and the
                // scroll is started from PUT afterwards.
                if (cursor_row == LAST_ROW) begin
                  scroll_pending <= 1'b1;
                end else begin
                  cursor_row <= cursor_row + 5'd1;
                end
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else begin
              case (cmd_data)
                CODE_LF: begin
                  cursor_col <= '0;
                  if (cursor_row == LAST_ROW) begin
                    seq       <= '0;
                    ram_raddr <= COLS_A;
                    state     <= SCROLL_RD;
                  end else begin
                    cursor_row <= cursor_row + 5'd1;
                  end
                end
                CODE_CR: begin
                  cursor_col <= '0;
                end
                CODE_BS: begin
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                    ram_wren   <= 1'b1;
                    ram_waddr  <= cur_addr - 12'd1;
                    ram_wdata  <= BLANK;
                    state      <= PUT;
                  end
                end
                CODE_FF: begin
                  ram_wren  <= 1'b1;
                  ram_waddr <= '0;
                  ram_wdata <= BLANK;
                  seq       <= 12'd1;
                  state     <= CLEAR;
                end
                default: begin
                end
              endcase
            end
          end
        end

        PUT: begin
          ram_wren <= 1'b0;
          if (scroll_pending) begin
            scroll_pending <= 1'b0;
            seq            <= '0;
            ram_raddr      <= COLS_A;
            state          <= SCROLL_RD;
          end else begin
            state <= IDLE;
          end
        end

        SCROLL_RD: begin
          ram_wren <= 1'b0;
          state    <= SCROLL_WR;
        end

        SCROLL_WR: begin
          ram_wren  <= 1'b1;
          ram_waddr <= seq;
          ram_wdata <= ram_rdata;
          seq       <= seq + 12'd1;
          if (seq == SHIFT_LAST) begin
            state <= SCROLL_BLANK;
          end else begin
            ram_raddr <= seq + COLS_A + 12'd1;
            state     <= SCROLL_RD;
          end
        end

        SCROLL_BLANK: begin
          if (seq == TOTAL) begin
            ram_wren <= 1'b0;
            state    <= IDLE;
          end else begin
            ram_wren  <= 1'b1;
            ram_waddr <= seq;
            ram_wdata <= BLANK;
            seq       <= seq + 12'd1;
          end
        end

        CLEAR: begin
          if (seq == TOTAL) begin
            ram_wren   <= 1'b0;
            cursor_col <= '0;
            cursor_row <= '0;
            state      <= IDLE;
          end else begin
            ram_wren  <= 1'b1;
            ram_waddr <= seq;
            ram_wdata <= BLANK;
            seq       <= seq + 12'd1;
          end
        end

        default: begin
          ram_wren <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Self-checking bench for vga_console_ctrl.
// A synchronous character RAM model sits on the DUT's RAM ports; a separate
// screen model (array + cursor) applies each command using plain console
// rules and is compared against the RAM contents and the DUT cursor.
module tb_vga_console_ctrl;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_data;
  logic        ram_wren;
  logic [11:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic [11:0] ram_raddr;
  logic [7:0]  ram_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:4095];
  logic        mem_init = 1'b0;
  logic [11:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic        busy_seen;

  logic [7:0] scr [0:CELLS-1];
  int         ecol;
  int         erow;

  vga_console_ctrl dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .ram_wren   (ram_wren),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous character RAM with one cycle of read latency.
  always @(posedge vga_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
    end else if (ram_wren === 1'b1) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
  end

  // Write log and busy observation, sampled mid-cycle.
  always @(negedge vga_clk) begin
    if (ram_wren === 1'b1) begin
      wr_addr.push_back(ram_waddr);
      wr_data.push_back(ram_wdata);
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  // ---------------- reference screen model ----------------
  function automatic void model_fill_addr();
    for (int i = 0; i < CELLS; i++) scr[i] = 8'(i);
  endfunction

  function automatic void model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r*COLS + c] = scr[(r+1)*COLS + c];
    for (int c = 0; c < COLS; c++) scr[(ROWS-1)*COLS + c] = 8'h20;
  endfunction

  function automatic void model_newline();
    ecol = 0;
    if (erow == ROWS - 1) model_scroll();
    else erow = erow + 1;
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[erow*COLS + ecol] = b;
      ecol = ecol + 1;
      if (ecol == COLS) model_newline();
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h0D) begin
      ecol = 0;
    end else if (b == 8'h08) begin
      if (ecol > 0) begin
        ecol = ecol - 1;
        scr[erow*COLS + ecol] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
      ecol = 0;
      erow = 0;
    end
  endfunction

  function automatic int screen_diffs();
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== scr[i]) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    busy_seen = 1'b0;
  endtask

  // Presents one byte and returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge vga_clk);
    while (cmd_ready !== 1'b1 && n < 10000) begin
      @(negedge vga_clk);
      n++;
    end
    if (n >= 10000) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%b required=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(posedge vga_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge vga_clk);
    while (cmd_ready !== 1'b1 && n < 10000) begin
      @(negedge vga_clk);
      n++;
    end
    if (n >= 10000) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: cmd_ready=%b required=1", cmd_ready);
    end
  endtask

  task automatic send_model(input logic [7:0] b);
    send_byte(b);
    wait_idle();
    model_apply(b);
  endtask

  task automatic reload_ram();
    @(negedge vga_clk);
    mem_init = 1'b1;
    @(posedge vga_clk);
    #1;
    mem_init = 1'b0;
    model_fill_addr();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    mem_init  = 1'b1;
    @(posedge vga_clk);
    #1;
    mem_init = 1'b0;
    model_fill_addr();
    ecol = 0;
    erow = 0;
    @(negedge vga_clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got=%b exp=0", cmd_ready); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL rst_wren: got=%b exp=0", ram_wren); end
    total++; if (ram_waddr !== 12'd0) begin bad++; $display("[TB] FAIL rst_waddr: got=%0d exp=0", ram_waddr); end
    total++; if (ram_wdata !== 8'd0) begin bad++; $display("[TB] FAIL rst_wdata: got=%h exp=00", ram_wdata); end
    total++; if (ram_raddr !== 12'd0) begin bad++; $display("[TB] FAIL rst_raddr: got=%0d exp=0", ram_raddr); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got=%b exp=0", busy); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("[TB] FAIL rst_cursor: got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_before_edge: got=%b exp=0", cmd_ready); end
    @(posedge vga_clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_edge: got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_put_single();
    send_byte(8'h41);
    total++; if (ram_wren !== 1'b1) begin bad++; $display("[TB] FAIL put_wren: got=%b exp=1", ram_wren); end
    total++; if (ram_waddr !== 12'd0) begin bad++; $display("[TB] FAIL put_waddr: got=%0d exp=0", ram_waddr); end
    total++; if (ram_wdata !== 8'h41) begin bad++; $display("[TB] FAIL put_wdata: got=%h exp=41", ram_wdata); end
    total++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin bad++; $display("[TB] FAIL put_cursor: got=(%0d,%0d) exp=(1,0)", cursor_col, cursor_row); end
    @(posedge vga_clk);
    #1;
    total++; if (ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL put_wren_one_cycle: got=%b exp=0", ram_wren); end
    wait_idle();
    model_apply(8'h41);
  endtask

  task automatic test_row_fill();
    send_model(8'h0D);
    clear_log();
    for (int i = 0; i < COLS; i++) send_model(8'h30);
    total++; if (wr_addr.size() != COLS) begin bad++; $display("[TB] FAIL fill_count: got=%0d exp=%0d", wr_addr.size(), COLS); end
    total++; if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 12'd69) begin bad++; $display("[TB] FAIL fill_last_addr: got=%0d exp=69", (wr_addr.size() == 0) ? -1 : int'(wr_addr[wr_addr.size()-1])); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin bad++; $display("[TB] FAIL fill_cursor: got=(%0d,%0d) exp=(0,1)", cursor_col, cursor_row); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("[TB] FAIL fill_no_scroll: busy_seen=%b exp=0", busy_seen); end
  endtask

  task automatic test_backspace();
    send_model(8'h0A);
    send_model(8'h0A);
    send_model(8'h0A);
    clear_log();
    send_model(8'h08);
    total++; if (wr_addr.size() != 0) begin bad++; $display("[TB] FAIL bs_col0_write: got=%0d writes exp=0", wr_addr.size()); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd4) begin bad++; $display("[TB] FAIL bs_col0_cursor: got=(%0d,%0d) exp=(0,4)", cursor_col, cursor_row); end
    send_model(8'h61);
    send_model(8'h62);
    send_model(8'h63);
    clear_log();
    send_model(8'h08);
    total++; if (wr_addr.size() != 1 || wr_addr[0] !== 12'd282 || wr_data[0] !== 8'h20) begin
      bad++;
      $display("[TB] FAIL bs_write: got=%0d writes first=(%0d,%h) exp=1 write (282,20)", wr_addr.size(),
               (wr_addr.size() == 0) ? -1 : int'(wr_addr[0]), (wr_data.size() == 0) ? 8'h00 : wr_data[0]);
    end
    total++; if (cursor_col !== 7'd2 || cursor_row !== 5'd4) begin bad++; $display("[TB] FAIL bs_cursor: got=(%0d,%0d) exp=(2,4)", cursor_col, cursor_row); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    int d;
    int cur_bad = 0;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 83) b = 8'h0D;
      else if (r < 91) b = 8'h08;
      else if (r < 95) b = 8'($urandom_range(128, 255));
      else             b = 8'h07;
      send_model(b);
      total++;
      if (int'(cursor_col) != ecol || int'(cursor_row) != erow) begin
        bad++;
        cur_bad++;
        if (cur_bad <= 5)
          $display("[TB] FAIL rand_cursor: byte=%h got=(%0d,%0d) exp=(%0d,%0d)", b, cursor_col, cursor_row, ecol, erow);
      end
    end
    d = screen_diffs();
    total++; if (d != 0) begin bad++; $display("[TB] FAIL rand_screen: got=%0d differing cells exp=0", d); end
  endtask

  task automatic test_scroll();
    int asc_err = 0;
    int d;
    send_model(8'h0D);
    while (erow < ROWS - 1) send_model(8'h0A);
    for (int i = 0; i < 5; i++) send_model(8'h2A);
    reload_ram();
    clear_log();
    send_byte(8'h0A);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL scroll_busy: got=%b exp=1", busy); end
    wait_idle();
    model_apply(8'h0A);
    total++; if (wr_addr.size() != CELLS) begin bad++; $display("[TB] FAIL scroll_count: got=%0d exp=%0d", wr_addr.size(), CELLS); end
    for (int i = 1; i < wr_addr.size(); i++) if (wr_addr[i] <= wr_addr[i-1]) asc_err++;
    total++; if (asc_err != 0) begin bad++; $display("[TB] FAIL scroll_ascending: got=%0d out-of-order exp=0", asc_err); end
    total++; if (mem[0] !== 8'd70) begin bad++; $display("[TB] FAIL scroll_addr0: got=%h exp=46", mem[0]); end
    total++; if (mem[2029] !== 8'h33) begin bad++; $display("[TB] FAIL scroll_addr2029: got=%h exp=33", mem[2029]); end
    d = screen_diffs();
    total++; if (d != 0) begin bad++; $display("[TB] FAIL scroll_screen: got=%0d differing cells exp=0", d); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin bad++; $display("[TB] FAIL scroll_cursor: got=(%0d,%0d) exp=(0,29)", cursor_col, cursor_row); end
  endtask

  task automatic test_clear();
    int derr = 0;
    clear_log();
    send_byte(8'h0C);
    total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL clear_start: ready=%b busy=%b exp ready=0 busy=1", cmd_ready, busy); end
    wait_idle();
    model_apply(8'h0C);
    total++; if (wr_addr.size() != CELLS) begin bad++; $display("[TB] FAIL clear_count: got=%0d exp=%0d", wr_addr.size(), CELLS); end
    for (int i = 0; i < wr_addr.size(); i++) if (int'(wr_addr[i]) != i || wr_data[i] !== 8'h20) derr++;
    total++; if (derr != 0) begin bad++; $display("[TB] FAIL clear_writes: got=%0d bad writes exp=0", derr); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("[TB] FAIL clear_cursor: got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
    total++; if (screen_diffs() != 0) begin bad++; $display("[TB] FAIL clear_screen: got=%0d differing cells exp=0", screen_diffs()); end
  endtask

  task automatic test_reset_mid_scroll();
    int n = 0;
    while (erow < ROWS - 1) send_model(8'h0A);
    send_byte(8'h0A);
    repeat (100) @(posedge vga_clk);
    #1;
    while (ram_wren !== 1'b1 && n < 8) begin
      @(posedge vga_clk);
      #1;
      n++;
    end
    total++; if (busy !== 1'b1 || ram_wren !== 1'b1) begin bad++; $display("[TB] FAIL mid_in_scroll: busy=%b wren=%b exp 1/1", busy, ram_wren); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL mid_wren: got=%b exp=0", ram_wren); end
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy_ready: busy=%b ready=%b exp 0/0", busy, cmd_ready); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("[TB] FAIL mid_cursor: got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
    clear_log();
    repeat (3) @(negedge vga_clk);
    total++; if (wr_addr.size() != 0) begin bad++; $display("[TB] FAIL mid_no_writes: got=%0d exp=0", wr_addr.size()); end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready_early: got=%b exp=0", cmd_ready); end
    @(posedge vga_clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready_release: got=%b exp=1", cmd_ready); end
  endtask

  initial begin
    busy_seen = 1'b0;
    test_reset();
    test_put_single();
    test_row_fill();
    test_backspace();
    test_random();
    test_scroll();
    test_clear();
    test_reset_mid_scroll();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
